// File: rtl/urna_vote_controller_if.sv
// Keypad-to-controller and controller-to-LCD signal bundle for the ballot box.
// The slave modport is the vote controller; the master side drives keys and reads the display state.
interface urna_vote_controller_if;
    logic       iKEY_VALID;
    logic [3:0] iKEY_CODE;
    logic [2:0] estado;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [3:0] c1Dez;
    logic [3:0] c1Uni;
    logic [3:0] c2Dez;
    logic [3:0] c2Uni;
    logic [3:0] c3Dez;
    logic [3:0] c3Uni;
    logic [3:0] c4Dez;
    logic [3:0] c4Uni;
    logic [3:0] nDez;
    logic [3:0] nUni;
    logic [3:0] tDez;
    logic [3:0] tUni;
    logic [3:0] cadVencedr1;
    logic [3:0] cadVencedr2;
    logic       oVOTE_DONE;
    logic       oCLOSED;

    modport master (
        output iKEY_VALID, iKEY_CODE,
        input  estado, bcd1, bcd2,
        input  c1Dez, c1Uni, c2Dez, c2Uni, c3Dez, c3Uni, c4Dez, c4Uni,
        input  nDez, nUni, tDez, tUni,
        input  cadVencedr1, cadVencedr2, oVOTE_DONE, oCLOSED
    );

    modport slave (
        input  iKEY_VALID, iKEY_CODE,
        output estado, bcd1, bcd2,
        output c1Dez, c1Uni, c2Dez, c2Uni, c3Dez, c3Uni, c4Dez, c4Uni,
        output nDez, nUni, tDez, tUni,
        output cadVencedr1, cadVencedr2, oVOTE_DONE, oCLOSED
    );
endinterface

// File: rtl/urna_vote_controller.sv
// Voting-session FSM for the electronic ballot box: number entry, BCD tallies and a
// sequential winner search feeding the LCD content generator. All outputs are registered.
module urna_vote_controller #(
    parameter logic [7:0]  CAND1        = 8'h11,
    parameter logic [7:0]  CAND2        = 8'h22,
    parameter logic [7:0]  CAND3        = 8'h33,
    parameter logic [7:0]  CAND4        = 8'h44,
    parameter int unsigned CONFIRM_HOLD = 100000000,
    parameter int unsigned APUR_HOLD    = 50000000
) (
    input logic                  iCLK,
    input logic                  iRST_N,
    urna_vote_controller_if.slave bus
);

    localparam int unsigned HoldMax = (CONFIRM_HOLD > APUR_HOLD) ? CONFIRM_HOLD : APUR_HOLD;
    localparam int unsigned DwellW  = $clog2(HoldMax);

    localparam logic [3:0] KeyConfirma = 4'd10;
    localparam logic [3:0] KeyCorrige  = 4'd11;
    localparam logic [3:0] KeyFim      = 4'd12;
    localparam logic [3:0] NoDigit     = 4'hF;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StEnter     = 3'd1,
        StAsk       = 3'd2,
        StConfirmed = 3'd3,
        StWinner    = 3'd4,
        StApur      = 3'd5,
        StPartial   = 3'd6,
        StTotals    = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          bcd1_q, bcd1_d;
    logic [3:0]          bcd2_q, bcd2_d;
    // Entries 0..3 candidates, 4 null votes, 5 total.
    logic [5:0][7:0]     tally_q, tally_d;
    logic [7:0]          win_q, win_d;
    logic [7:0]          best_q, best_d;
    logic [DwellW-1:0]   dwell_q, dwell_d;
    logic                done_q, done_d;
    logic                closed_q, closed_d;

    logic                key_ok;
    logic                is_digit;
    logic                is_confirma;
    logic                is_corrige;
    logic                is_fim;
    logic [2:0]          vote_idx;
    logic [1:0]          exam_idx;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) begin
            return v;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] cand_num(input logic [1:0] idx);
        unique case (idx)
            2'd0:    return CAND1;
            2'd1:    return CAND2;
            2'd2:    return CAND3;
            default: return CAND4;
        endcase
    endfunction

    assign key_ok      = bus.iKEY_VALID && (bus.iKEY_CODE <= KeyFim);
    assign is_digit    = key_ok && (bus.iKEY_CODE <= 4'd9);
    assign is_confirma = key_ok && (bus.iKEY_CODE == KeyConfirma);
    assign is_corrige  = key_ok && (bus.iKEY_CODE == KeyCorrige);
    assign is_fim      = key_ok && (bus.iKEY_CODE == KeyFim);
    assign exam_idx    = dwell_q[1:0];

    always_comb begin
        vote_idx = 3'd4;
        if ({bcd1_q, bcd2_q} == CAND1) begin
            vote_idx = 3'd0;
        end else if ({bcd1_q, bcd2_q} == CAND2) begin
            vote_idx = 3'd1;
        end else if ({bcd1_q, bcd2_q} == CAND3) begin
            vote_idx = 3'd2;
        end else if ({bcd1_q, bcd2_q} == CAND4) begin
            vote_idx = 3'd3;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd1_d   = bcd1_q;
        bcd2_d   = bcd2_q;
        tally_d  = tally_q;
        win_d    = win_q;
        best_d   = best_q;
        dwell_d  = dwell_q;
        done_d   = 1'b0;
        closed_d = closed_q;

        unique case (state_q)
            StIdle: begin
                if (is_confirma) begin
                    state_d = StEnter;
                    bcd1_d  = NoDigit;
                    bcd2_d  = NoDigit;
                end else if (is_fim) begin
                    state_d  = StApur;
                    closed_d = 1'b1;
                    dwell_d  = '0;
                    best_d   = '0;
                    win_d    = {NoDigit, NoDigit};
                end
            end
            StEnter: begin
                if (is_digit) begin
                    if (bcd1_q == NoDigit) begin
                        bcd1_d = bus.iKEY_CODE;
                    end else if (bcd2_q == NoDigit) begin
                        bcd2_d = bus.iKEY_CODE;
                    end
                end else if (is_confirma) begin
                    if (bcd1_q != NoDigit && bcd2_q != NoDigit) begin
                        state_d = StAsk;
                    end
                end else if (is_corrige) begin
                    bcd1_d = NoDigit;
                    bcd2_d = NoDigit;
                end
            end
            StAsk: begin
                if (is_confirma) begin
                    state_d = StConfirmed;
                    dwell_d = '0;
                    done_d  = 1'b1;
                    for (int unsigned i = 0; i < 5; i++) begin
                        if (vote_idx == 3'(i)) begin
                            tally_d[i] = bcd_inc(tally_q[i]);
                        end
                    end
                    tally_d[5] = bcd_inc(tally_q[5]);
                end else if (is_corrige) begin
                    state_d = StEnter;
                    bcd1_d  = NoDigit;
                    bcd2_d  = NoDigit;
                end
            end
            StConfirmed: begin
                if (dwell_q == DwellW'(CONFIRM_HOLD - 1)) begin
                    state_d = StIdle;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            StApur: begin
                // Strictly-greater replacement keeps ties on the lowest index; zero counts never win.
                if (dwell_q < DwellW'(4)) begin
                    if (tally_q[exam_idx] > best_q) begin
                        best_d = tally_q[exam_idx];
                        win_d  = cand_num(exam_idx);
                    end
                end
                if (dwell_q == DwellW'(APUR_HOLD - 1)) begin
                    state_d = StWinner;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            StWinner: begin
                if (is_confirma) begin
                    state_d = StPartial;
                end
            end
            StPartial: begin
                if (is_confirma) begin
                    state_d = StTotals;
                end
            end
            StTotals: begin
                if (is_confirma) begin
                    state_d = StWinner;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= StIdle;
            bcd1_q   <= NoDigit;
            bcd2_q   <= NoDigit;
            tally_q  <= '0;
            win_q    <= {NoDigit, NoDigit};
            best_q   <= '0;
            dwell_q  <= '0;
            done_q   <= 1'b0;
            closed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd1_q   <= bcd1_d;
            bcd2_q   <= bcd2_d;
            tally_q  <= tally_d;
            win_q    <= win_d;
            best_q   <= best_d;
            dwell_q  <= dwell_d;
            done_q   <= done_d;
            closed_q <= closed_d;
        end
    end

    assign bus.estado      = state_q;
    assign bus.bcd1        = bcd1_q;
    assign bus.bcd2        = bcd2_q;
    assign bus.c1Dez       = tally_q[0][7:4];
    assign bus.c1Uni       = tally_q[0][3:0];
    assign bus.c2Dez       = tally_q[1][7:4];
    assign bus.c2Uni       = tally_q[1][3:0];
    assign bus.c3Dez       = tally_q[2][7:4];
    assign bus.c3Uni       = tally_q[2][3:0];
    assign bus.c4Dez       = tally_q[3][7:4];
    assign bus.c4Uni       = tally_q[3][3:0];
    assign bus.nDez        = tally_q[4][7:4];
    assign bus.nUni        = tally_q[4][3:0];
    assign bus.tDez        = tally_q[5][7:4];
    assign bus.tUni        = tally_q[5][3:0];
    assign bus.cadVencedr1 = win_q[7:4];
    assign bus.cadVencedr2 = win_q[3:0];
    assign bus.oVOTE_DONE  = done_q;
    assign bus.oCLOSED     = closed_q;

endmodule

// File: tb/tb_urna_vote_controller.sv
// Directed bench for urna_vote_controller: votes, entry rules, saturation, winner search
// and asynchronous reset, with tally snapshots checked by a scoreboard on each oVOTE_DONE.
module tb_urna_vote_controller;

    localparam logic [3:0] KC = 4'd10;
    localparam logic [3:0] KR = 4'd11;
    localparam logic [3:0] KF = 4'd12;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   m_cnt [6];
    logic [47:0] sb_q [$];
    logic done_prev;

    urna_vote_controller_if bus ();

    urna_vote_controller #(
        .CONFIRM_HOLD (8),
        .APUR_HOLD    (10)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] obs_tally();
        return {bus.c1Dez, bus.c1Uni, bus.c2Dez, bus.c2Uni, bus.c3Dez, bus.c3Uni,
                bus.c4Dez, bus.c4Uni, bus.nDez, bus.nUni, bus.tDez, bus.tUni};
    endfunction

    function automatic logic [47:0] pack_model();
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[47-8*i -: 8] = {4'(m_cnt[i] / 10), 4'(m_cnt[i] % 10)};
        end
        return r;
    endfunction

    function automatic void model_vote(input logic [3:0] d1, input logic [3:0] d2);
        int num;
        int idx;
        num = 10 * int'(d1) + int'(d2);
        case (num)
            11: idx = 0;
            22: idx = 1;
            33: idx = 2;
            44: idx = 3;
            default: idx = 4;
        endcase
        if (m_cnt[idx] < 99) m_cnt[idx]++;
        if (m_cnt[5] < 99) m_cnt[5]++;
    endfunction

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.iKEY_VALID = 1'b1;
        bus.iKEY_CODE  = code;
        @(negedge clk);
        bus.iKEY_VALID = 1'b0;
        bus.iKEY_CODE  = 4'd0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_estado"}, 48'(bus.estado), 48'd0);
        check({tag, "_bcd"}, 48'({bus.bcd1, bus.bcd2}), 48'hFF);
        check({tag, "_tally"}, obs_tally(), 48'd0);
        check({tag, "_win"}, 48'({bus.cadVencedr1, bus.cadVencedr2}), 48'hFF);
        check({tag, "_flags"}, 48'({bus.oVOTE_DONE, bus.oCLOSED}), 48'd0);
    endtask

    // From state 2: final CONFIRMA, then measure the state-3 dwell.
    task automatic finish_vote(input logic [3:0] d1, input logic [3:0] d2);
        int n;
        model_vote(d1, d2);
        sb_q.push_back(pack_model());
        press(KC);
        check("confirmed_bcd", 48'({bus.bcd1, bus.bcd2}), 48'({d1, d2}));
        n = 0;
        while (bus.estado == 3'd3 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("confirm_dwell", 48'(n), 48'd8);
        check("back_idle", 48'(bus.estado), 48'd0);
        check("sb_drained", 48'(sb_q.size()), 48'd0);
    endtask

    task automatic vote(input logic [3:0] d1, input logic [3:0] d2);
        press(KC);
        press(d1);
        press(d2);
        press(KC);
        check("ask_state", 48'(bus.estado), 48'd2);
        finish_vote(d1, d2);
    endtask

    task automatic run_apur(input logic [7:0] exp_win);
        int n;
        press(KF);
        check("apur_closed", 48'(bus.oCLOSED), 48'd1);
        n = 0;
        while (bus.estado == 3'd5 && n < 50) begin
            n++;
            if (n == 5) check("win_by_5th", 48'({bus.cadVencedr1, bus.cadVencedr2}), 48'(exp_win));
            @(negedge clk);
        end
        check("apur_dwell", 48'(n), 48'd10);
        check("winner_state", 48'(bus.estado), 48'd4);
        check("winner", 48'({bus.cadVencedr1, bus.cadVencedr2}), 48'(exp_win));
    endtask

    // Scoreboard: each oVOTE_DONE pops the tally snapshot expected for that vote.
    always @(negedge clk) begin
        if (bus.oVOTE_DONE) begin
            check("done_width", 48'(done_prev), 48'd0);
            if (sb_q.size() == 0) begin
                check("done_unexpected", 48'd1, 48'd0);
            end else begin
                check("vote_tally", obs_tally(), sb_q.pop_front());
                check("done_estado", 48'(bus.estado), 48'd3);
            end
        end
        done_prev = bus.oVOTE_DONE;
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        done_prev = 1'b0;
        bus.iKEY_VALID = 1'b0;
        bus.iKEY_CODE  = 4'd0;
        rst_n = 1'b0;
        clear_model();
        #12;
        check_reset_state("rst");
        rst_n = 1'b1;

        // Ignored keys in IDLE
        press(4'd14);
        check("idle_code14", 48'(bus.estado), 48'd0);
        press(4'd5);
        check("idle_digit", 48'(bus.estado), 48'd0);

        // Vote for 22 with per-step checks
        press(KC);
        check("enter_state", 48'(bus.estado), 48'd1);
        check("enter_bcd", 48'({bus.bcd1, bus.bcd2}), 48'hFF);
        press(4'd2);
        press(4'd2);
        check("entered_22", 48'({bus.bcd1, bus.bcd2}), 48'h22);
        press(KC);
        check("ask_22", 48'(bus.estado), 48'd2);
        press(4'd7);
        check("ask_digit_ign", 48'({bus.bcd1, bus.bcd2}), 48'h22);
        finish_vote(4'd2, 4'd2);
        check("c2_after", 48'({bus.c2Dez, bus.c2Uni}), 48'h01);

        // Null vote and entry rules
        press(KC);
        press(4'd5);
        press(KC);
        check("half_confirm_ign", 48'(bus.estado), 48'd1);
        press(4'd13);
        check("code13_ign", 48'({bus.bcd1, bus.bcd2}), 48'h5F);
        press(4'd7);
        press(4'd9);
        check("third_digit_ign", 48'({bus.bcd1, bus.bcd2}), 48'h57);
        press(KC);
        check("ask_57", 48'(bus.estado), 48'd2);
        finish_vote(4'd5, 4'd7);
        check("null_after", 48'({bus.nDez, bus.nUni}), 48'h01);

        // Correction paths
        press(KC);
        press(4'd1);
        press(4'd1);
        press(KC);
        press(KR);
        check("corrige_state", 48'(bus.estado), 48'd1);
        check("corrige_bcd", 48'({bus.bcd1, bus.bcd2}), 48'hFF);
        press(4'd3);
        press(KR);
        check("enter_corrige", 48'({bus.bcd1, bus.bcd2}), 48'hFF);
        press(4'd3);
        press(4'd3);
        press(KC);
        finish_vote(4'd3, 4'd3);
        check("c3_after", 48'({bus.c3Dez, bus.c3Uni}), 48'h01);

        // Winner with tie on 2 votes: lowest index (22) wins
        do_reset();
        vote(4'd2, 4'd2);
        vote(4'd2, 4'd2);
        vote(4'd3, 4'd3);
        vote(4'd3, 4'd3);
        vote(4'd1, 4'd1);
        run_apur(8'h22);
        press(4'd5);
        check("winner_digit_ign", 48'(bus.estado), 48'd4);
        press(KC);
        check("to_partial", 48'(bus.estado), 48'd6);
        press(KF);
        check("partial_fim_ign", 48'(bus.estado), 48'd6);
        press(KC);
        check("to_totals", 48'(bus.estado), 48'd7);
        press(KC);
        check("to_winner", 48'(bus.estado), 48'd4);
        check("closed_held", 48'(bus.oCLOSED), 48'd1);
        check("tally_held", obs_tally(), pack_model());

        // Saturation at 99
        do_reset();
        repeat (100) vote(4'd1, 4'd1);
        check("sat_c1", 48'({bus.c1Dez, bus.c1Uni}), 48'h99);
        check("sat_total", 48'({bus.tDez, bus.tUni}), 48'h99);
        run_apur(8'h11);

        // No votes: winner stays F,F
        do_reset();
        run_apur(8'hFF);

        // Asynchronous reset on the 3rd cycle of APURACAO
        do_reset();
        vote(4'd4, 4'd4);
        press(KF);
        @(negedge clk);
        @(negedge clk);
        check("mid_apur", 48'(bus.estado), 48'd5);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        vote(4'd4, 4'd4);
        check("post_rst_c4", 48'({bus.c4Dez, bus.c4Uni}), 48'h01);

        check("sb_empty", 48'(sb_q.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
